regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port general-purpose register file for the MIPS32 pipeline core.
//  Provides NR asynchronous read ports, 2 synchronous write ports (ALU/WB and load-return) and r0 hardwired to zero.
//  Also provides a per-register busy scoreboard: ID marks a destination pending, and the write that retires it clears it.
//  ID uses rbusy to stall on long-latency producers.
// PARAMETERS
//  DW  32  data width in bits
//  AW  5   address width; DEPTH = 2**AW registers, r0 included
//  NR  2   number of read ports (>=1)
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  clrn      in   1      synchronous active-low reset, sampled on posedge clk
//  ra        in   NR*AW  read addresses; port k = ra[k*AW +: AW]
//  qa        out  NR*DW  read data; port k = qa[k*DW +: DW]
//  rbusy     out  NR     busy bit of the register addressed by port k
//  we0       in   1      write enable, port 0
//  wn0       in   AW     write address, port 0
//  d0        in   DW     write data, port 0
//  we1       in   1      write enable, port 1 (higher priority)
//  wn1       in   AW     write address, port 1
//  d1        in   DW     write data, port 1
//  iss_en    in   1      issue: mark iss_rn busy
//  iss_rn    in   AW     destination register being issued
//  busy_cnt  out  AW+1   number of registers currently busy
// BEHAVIOUR
//  - Reset (clrn=0 at posedge): all registers 1..DEPTH-1 <= 0; all busy bits <= 0; busy_cnt <= 0.
//    Reset dominates every concurrent write or issue. Asynchronous outputs follow the cleared state.
//  - Read: combinational. qa[k] = 0 when ra[k]==0, else reg[ra[k]]. rbusy[k] = busy[ra[k]]. r0 is never busy.
//  - Write: on posedge, if weX && wnX!=0 then reg[wnX] <= dX.
//    Writes to r0 are ignored and clear nothing.
//  - Same-address dual write (we0 && we1 && wn0==wn1): port 1 data wins. The busy bit is cleared once.
//  - Scoreboard per posedge, for each reg r != 0:
//      set = iss_en && iss_rn==r;
//      clr = (we0 && wn0==r) || (we1 && wn1==r);
//      set && clr -> busy <= 1 (new producer wins); set only -> 1; clr only -> 0; else hold.
//    Issuing an already-busy register keeps it busy with no count change.
//    Clearing a non-busy register has no effect.
//  - busy_cnt: registered population count of busy bits, updated in the same cycle as busy.
//    Maintained by increment/decrement by net change (range -2..+1 per cycle), never recomputed from scratch.
//    It must never wrap: 0 <= busy_cnt <= DEPTH-1.
//  - Latency: a write is visible on qa the cycle after the write edge. Same for busy/rbusy after issue or clear.
//  - All write and scoreboard updates in a cycle use the pre-edge state.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - Read port k returns same-cycle write data combinationally when ra[k] matches a valid write (weX && wnX==ra[k]!=0).
//      d1 takes priority over d0.
//    - rbusy[k] is forced 0 when that register is being cleared this cycle and not simultaneously issued.
//    - Removes the one-cycle WB->ID hazard.
//  Undefined: qa and rbusy reflect stored state only. No bypass muxes are built.
// TESTING
//  1 reset: write r5=0x1234 then clrn=0 for 1 cycle -> qa(r5)=0, all rbusy=0, busy_cnt=0.
//  2 r0: we0=1 wn0=0 d0=0xFFFFFFFF; iss_en, iss_rn=0 -> qa(ra=0)=0, rbusy=0, busy_cnt unchanged.
//  3 dual write: we0=we1=1, wn0=wn1=7, d0=0xA, d1=0xB -> next cycle qa(r7)=0xB.
//  4 scoreboard: issue r3, then r4 -> busy_cnt=2.
//    Then we1 to r3 with iss r3 in the same cycle -> r3 still busy, busy_cnt=2.
//    Then we0 r3 and we1 r4 -> busy_cnt=0.
//  5 bypass: we1 wn1=9 d1=0x55, ra=9 in the same cycle.
//    With REGFILE_BYPASS_EN -> qa=0x55, rbusy=0. Without -> old value; 0x55 next cycle.
//  6 reset mid-op: clrn=0 with we0, we1 and iss_en all active -> all regs 0, busy_cnt=0.
//    Then issue all 31 regs -> busy_cnt=31, no wrap.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//   General-purpose register file for the MIPS32 pipeline core, with a
//   per-register busy scoreboard.
//
//   - NR combinational read ports.
//   - Two synchronous write ports: port 0 (ALU/WB) and port 1 (load return).
//     Port 1 has priority when both ports target the same register.
//   - r0 reads as zero, ignores writes and is never busy.
//   - Scoreboard: ID marks a destination busy with iss_en/iss_rn. A write to
//     that register clears the bit. If the register is issued and written in
//     the same cycle, the new producer wins and the bit stays set.
//   - busy_cnt tracks how many registers are busy. It is updated
//     incrementally from the net change in each cycle.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When defined, each read port forwards same-cycle write data (d1 before
//   d0). rbusy is also suppressed for a register whose producer is retiring
//   this cycle. When undefined, the outputs show stored state only.
//
// Parameters
//   DW  data width
//   AW  address width, DEPTH = 2**AW registers (r0 included)
//   NR  number of read ports
//
// Ports
//   clk       clock, all state changes on the rising edge
//   clrn      synchronous active-low reset
//   ra        read addresses, port k = ra[k*AW +: AW]
//   qa        read data,      port k = qa[k*DW +: DW]
//   rbusy     busy bit of the register addressed by each read port
//   we0/wn0/d0  write port 0
//   we1/wn1/d1  write port 1 (higher priority)
//   iss_en/iss_rn  issue: mark iss_rn busy
//   busy_cnt  number of busy registers
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NR*AW-1:0]   ra,
  output logic [NR*DW-1:0]   qa,
  output logic [NR-1:0]      rbusy,
  input  logic               we0,
  input  logic [AW-1:0]      wn0,
  input  logic [DW-1:0]      d0,
  input  logic               we1,
  input  logic [AW-1:0]      wn1,
  input  logic [DW-1:0]      d1,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_rn,
  output logic [AW:0]        busy_cnt
);

  localparam int DEPTH = 2 ** AW;

  // Storage. Entry 0 exists so any address can index the array directly.
  // It is cleared on reset and never written, and reads of r0 are also
  // forced to zero.
  logic [DW-1:0]    r_regs [0:DEPTH-1];
  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_busyCnt;

  // A write or issue that targets r0 has no effect, so it is filtered out here.
  logic w_wr0Valid;
  logic w_wr1Valid;
  logic w_issValid;

  assign w_wr0Valid = we0 && (wn0 != '0);
  assign w_wr1Valid = we1 && (wn1 != '0);
  assign w_issValid = iss_en && (iss_rn != '0);

  // One-hot decode of the scoreboard set (issue) and clear (retiring writes).
  logic [DEPTH-1:0] w_setVec;
  logic [DEPTH-1:0] w_clrVec;

  always_comb begin
    w_setVec = '0;
    w_clrVec = '0;
    if (w_issValid) w_setVec[iss_rn] = 1'b1;
    if (w_wr0Valid) w_clrVec[wn0]    = 1'b1;
    if (w_wr1Valid) w_clrVec[wn1]    = 1'b1;
  end

  // Setting a bit takes priority over clearing it, so a new producer issued
  // in the same cycle that an old one retires keeps the register busy.
  logic [DEPTH-1:0] w_busyNext;
  assign w_busyNext = (r_busy & ~w_clrVec) | w_setVec;

  // Net change in the count. An increment happens only when an idle register
  // is issued. A decrement happens only when a busy register is cleared and
  // not re-issued. If both write ports hit the same register, that register
  // is counted once.
  logic [DEPTH-1:0] w_fallVec;
  logic             w_inc;
  logic             w_dec0;
  logic             w_dec1;

  assign w_fallVec = r_busy & w_clrVec & ~w_setVec;
  assign w_inc     = w_issValid && !r_busy[iss_rn];
  assign w_dec0    = w_wr0Valid && w_fallVec[wn0];
  assign w_dec1    = w_wr1Valid && w_fallVec[wn1] &&
                     !(w_wr0Valid && (wn0 == wn1));

  // Register array update. Port 1 is written last so that it wins a
  // same-address collision.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wr0Valid) r_regs[wn0] <= d0;
      if (w_wr1Valid) r_regs[wn1] <= d1;
    end
  end

  // Scoreboard bits and the running count. Reset has priority over any
  // issue or write in the same cycle.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      r_busy    <= w_busyNext;
      r_busyCnt <= r_busyCnt + (AW+1)'(w_inc)
                             - (AW+1)'(w_dec0)
                             - (AW+1)'(w_dec1);
    end
  end

  assign busy_cnt = r_busyCnt;

  // Read ports
  for (genvar k = 0; k < NR; k++) begin : g_read
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_stored;
    logic          w_storedBusy;

    assign w_addr       = ra[k*AW +: AW];
    assign w_stored     = (w_addr == '0) ? '0 : r_regs[w_addr];
    assign w_storedBusy = (w_addr != '0) && r_busy[w_addr];

`ifdef REGFILE_BYPASS_EN
    // Forward data that is being written this cycle, so a consumer in ID
    // does not have to wait one extra cycle after WB. Port 1 is checked first.
    logic w_hit0;
    logic w_hit1;

    assign w_hit0 = w_wr0Valid && (wn0 == w_addr);
    assign w_hit1 = w_wr1Valid && (wn1 == w_addr);

    assign qa[k*DW +: DW] = w_hit1 ? d1 :
                            w_hit0 ? d0 : w_stored;

    // A producer that retires this cycle releases the stall right away,
    // unless a new producer claims the register in the same cycle.
    assign rbusy[k] = w_storedBusy &&
                      !(w_clrVec[w_addr] && !w_setVec[w_addr]);
`else
    assign qa[k*DW +: DW] = w_stored;
    assign rbusy[k]       = w_storedBusy;
`endif
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (default parameters, two read ports).
// A behavioural model holds register contents and busy flags as plain arrays.
// The busy count is taken as the population of the busy flags.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic              clk;
  logic              clrn;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  qa;
  logic [NR-1:0]     rbusy;
  logic              we0;
  logic [AW-1:0]     wn0;
  logic [DW-1:0]     d0;
  logic              we1;
  logic [AW-1:0]     wn1;
  logic [DW-1:0]     d1;
  logic              iss_en;
  logic [AW-1:0]     iss_rn;
  logic [AW:0]       busy_cnt;

  regfile_mp_sb #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .clk(clk), .clrn(clrn), .ra(ra), .qa(qa), .rbusy(rbusy),
    .we0(we0), .wn0(wn0), .d0(d0),
    .we1(we1), .wn1(wn1), .d1(d1),
    .iss_en(iss_en), .iss_rn(iss_rn), .busy_cnt(busy_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [DW-1:0] mRegs [32];
  bit            mBusy [32];

  int checks = 0;
  int errors = 0;

  // Compares one observed value with its expected value and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic int modelCount();
    int n = 0;
    for (int r = 1; r < 32; r++) if (mBusy[r]) n++;
    return n;
  endfunction

  // Expected read data, computed from the model and the inputs applied this cycle.
  function automatic logic [DW-1:0] expQa(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && wn1 == a) return d1;
    if (we0 && wn0 == a) return d0;
`endif
    return mRegs[a];
  endfunction

  // Expected busy flag for a read port.
  function automatic logic expBusy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (((we0 && wn0 == a) || (we1 && wn1 == a)) && !(iss_en && iss_rn == a))
      return 1'b0;
`endif
    return mBusy[a];
  endfunction

  // Drives one cycle's inputs, then waits for the combinational outputs to settle.
  task automatic applyStimulus(input logic c, input logic e0, input logic [AW-1:0] n0,
                               input logic [DW-1:0] v0, input logic e1,
                               input logic [AW-1:0] n1, input logic [DW-1:0] v1,
                               input logic ie, input logic [AW-1:0] irn,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    clrn = c; we0 = e0; wn0 = n0; d0 = v0; we1 = e1; wn1 = n1; d1 = v1;
    iss_en = ie; iss_rn = irn;
    ra[0 +: AW] = a0; ra[AW +: AW] = a1;
    #1;
  endtask

  // Checks every output against the model.
  task automatic compareAll();
    for (int k = 0; k < NR; k++) begin
      checkOutput($sformatf("qa%0d", k), 64'(qa[k*DW +: DW]),
                  64'(expQa(ra[k*AW +: AW])));
      checkOutput($sformatf("rbusy%0d", k), 64'(rbusy[k]),
                  64'(expBusy(ra[k*AW +: AW])));
    end
    checkOutput("busy_cnt", 64'(busy_cnt), 64'(modelCount()));
  endtask

  // Advances one clock and updates the model from the inputs held during that edge.
  task automatic tick();
    @(posedge clk);
    if (!clrn) begin
      for (int r = 0; r < 32; r++) begin
        mRegs[r] = '0;
        mBusy[r] = 1'b0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (iss_en && iss_rn == r)
          mBusy[r] = 1'b1;
        else if ((we0 && wn0 == r) || (we1 && wn1 == r))
          mBusy[r] = 1'b0;
      end
      if (we0 && wn0 != 0) mRegs[wn0] = d0;
      if (we1 && wn1 != 0) mRegs[wn1] = d1;
    end
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  function automatic logic [AW-1:0] randAddr();
    return ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                       : AW'($urandom_range(0, 31));
  endfunction

  initial begin
    // Initial reset, no checks until the state is defined
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset clears a written register
    applyStimulus(1, 1, 5, 32'h1234, 0, 0, 0, 1, 5, 5, 0);
    compareAll();
    tick();
    idle(5, 0);
    compareAll();
    checkOutput("r5_written", 64'(qa[DW-1:0]), 64'h1234);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    tick();
    idle(5, 0);
    compareAll();
    checkOutput("reset_r5", 64'(qa[DW-1:0]), 64'h0);
    checkOutput("reset_rbusy", 64'(rbusy), 64'h0);
    checkOutput("reset_cnt", 64'(busy_cnt), 64'h0);

    // r0 ignores writes and issues
    applyStimulus(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
    compareAll();
    tick();
    idle(0, 0);
    compareAll();
    checkOutput("r0_data", 64'(qa[DW-1:0]), 64'h0);
    checkOutput("r0_busy", 64'(rbusy[0]), 64'h0);
    checkOutput("r0_cnt", 64'(busy_cnt), 64'h0);

    // Same-address dual write: port 1 wins
    applyStimulus(1, 1, 7, 32'hA, 1, 7, 32'hB, 0, 0, 7, 0);
    compareAll();
    tick();
    idle(7, 0);
    compareAll();
    checkOutput("dual_write", 64'(qa[DW-1:0]), 64'hB);

    // Scoreboard sequence
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 3, 3, 4);
    compareAll();
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 4, 3, 4);
    compareAll();
    tick();
    idle(3, 4);
    compareAll();
    checkOutput("sb_cnt2", 64'(busy_cnt), 64'd2);
    applyStimulus(1, 0, 0, 0, 1, 3, 32'h33, 1, 3, 3, 4);
    compareAll();
    tick();
    idle(3, 4);
    compareAll();
    checkOutput("sb_reissue_busy", 64'(rbusy[0]), 64'h1);
    checkOutput("sb_reissue_cnt", 64'(busy_cnt), 64'd2);
    applyStimulus(1, 1, 3, 32'h3, 1, 4, 32'h4, 0, 0, 3, 4);
    compareAll();
    tick();
    idle(3, 4);
    compareAll();
    checkOutput("sb_cnt0", 64'(busy_cnt), 64'd0);

    // Bypass: same-cycle read of a register being written
    applyStimulus(1, 1, 9, 32'h11, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 1, 9, 32'h55, 0, 0, 9, 0);
    compareAll();
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_same", 64'(qa[DW-1:0]), 64'h55);
`else
    checkOutput("bypass_same", 64'(qa[DW-1:0]), 64'h11);
`endif
    checkOutput("bypass_busy", 64'(rbusy[0]), 64'h0);
    tick();
    idle(9, 0);
    compareAll();
    checkOutput("bypass_next", 64'(qa[DW-1:0]), 64'h55);

    // Reset during activity, then fill the scoreboard
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    tick();
    applyStimulus(0, 1, 6, 32'h66, 1, 8, 32'h88, 1, 10, 6, 8);
    tick();
    idle(6, 8);
    compareAll();
    checkOutput("mid_reset_r6", 64'(qa[DW-1:0]), 64'h0);
    checkOutput("mid_reset_cnt", 64'(busy_cnt), 64'h0);
    for (int r = 1; r < 32; r++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, AW'(r), AW'(r), 0);
      compareAll();
      tick();
    end
    idle(31, 1);
    compareAll();
    checkOutput("fill_cnt", 64'(busy_cnt), 64'd31);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    tick();
    idle(1, 0);
    checkOutput("fill_no_wrap", 64'(busy_cnt), 64'd31);

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    ($urandom_range(0, 1) != 0), randAddr(), $urandom(),
                    ($urandom_range(0, 1) != 0), randAddr(), $urandom(),
                    ($urandom_range(0, 9) < 6), randAddr(),
                    randAddr(), randAddr());
      compareAll();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
